// File: rtl/decoder_n_pipe.sv
// decoder_n_pipe: registered index-to-one-hot decoder behind a 2-entry valid/ready FIFO.
// Each accepted beat stores {one_hot, range_err}. The head entry drives the outputs.
// Optional feature macro DECODER_N_PIPE_ERR_CNT_EN adds a saturating 8-bit count of
// accepted out-of-range beats. When the macro is undefined, err_cnt is tied to zero.
module decoder_n_pipe #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned OUT_N = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  id_in,
    input  logic             en_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] one_hot_out,
    output logic             range_err,
    output logic [7:0]       err_cnt
);

    logic [OUT_N-1:0] r_data [2];
    logic             r_err  [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;

    logic [OUT_N-1:0] w_one_hot;
    logic             w_range_err;
    logic             w_in_range;
    logic             w_accept;
    logic             w_consume;
    logic [1:0]       w_count_nxt;

    // Handshake flags come only from the registered count, so there is no input-to-output path.
    always_comb begin
        in_ready  = (r_count < 2'd2);
        out_valid = (r_count != 2'd0);
        w_accept  = in_valid && in_ready;
        w_consume = out_valid && out_ready;
    end

    // Decode the incoming index. Out-of-range or disabled beats give an all-zero vector.
    always_comb begin
        w_one_hot   = '0;
        w_in_range  = (32'(id_in) < OUT_N);
        w_range_err = en_in && !w_in_range;
        for (int unsigned i = 0; i < OUT_N; i++) begin
            if (en_in && (32'(id_in) == i)) begin
                w_one_hot[i] = 1'b1;
            end
        end
    end

    // Occupancy update. A simultaneous accept and consume leaves the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_accept, w_consume})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Control state: count and the wrap-modulo-2 pointers. Reset discards all stored beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_tail <= ~r_tail;
            end
            if (w_consume) begin
                r_head <= ~r_head;
            end
        end
    end

    // Payload storage. It needs no reset because out_valid gates every read.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_data[r_tail] <= w_one_hot;
            r_err[r_tail]  <= w_range_err;
        end
    end

    // Present the head entry. An empty FIFO presents zeros.
    always_comb begin
        one_hot_out = '0;
        range_err   = 1'b0;
        if (out_valid) begin
            one_hot_out = r_data[r_head];
            range_err   = r_err[r_head];
        end
    end

`ifdef DECODER_N_PIPE_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of accepted out-of-range beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_accept && w_range_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_decoder_n_pipe.sv
// Directed bench for decoder_n_pipe with IN_W=7 and OUT_N=100.
// It follows DECODER_N_PIPE_ERR_CNT_EN to pick the expected err_cnt values.
module tb_decoder_n_pipe;

    localparam int unsigned IN_W  = 7;
    localparam int unsigned OUT_N = 100;

`ifdef DECODER_N_PIPE_ERR_CNT_EN
    localparam bit ErrCntEn = 1'b1;
`else
    localparam bit ErrCntEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  id_in;
    logic             en_in;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_N-1:0] one_hot_out;
    logic             range_err;
    logic [7:0]       err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_n_pipe #(
        .IN_W (IN_W),
        .OUT_N(OUT_N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_in      (id_in),
        .en_in      (en_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .one_hot_out(one_hot_out),
        .range_err  (range_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] bit_of(input int i);
        logic [127:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] exp_cnt(input int k);
        if (!ErrCntEn) return 128'd0;
        return (k > 255) ? 128'd255 : 128'(k);
    endfunction

    initial begin
        rst       = 1'b1;
        id_in     = '0;
        en_in     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_one_hot", 128'(one_hot_out), 128'd0);
        chk("rst_range_err", 128'(range_err), 128'd0);
        chk("rst_err_cnt", 128'(err_cnt), 128'd0);

        // Basic decode.
        in_valid = 1'b1; id_in = 7'h05; en_in = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("basic_valid", 128'(out_valid), 128'd1);
        chk("basic_one_hot", 128'(one_hot_out), bit_of(5));
        chk("basic_range_err", 128'(range_err), 128'd0);
        step();
        chk("basic_drained", 128'(out_valid), 128'd0);

        // Out of range.
        in_valid = 1'b1; id_in = 7'h64;
        step();
        in_valid = 1'b0;
        chk("oor_valid", 128'(out_valid), 128'd1);
        chk("oor_one_hot", 128'(one_hot_out), 128'd0);
        chk("oor_range_err", 128'(range_err), 128'd1);
        chk("oor_err_cnt", 128'(err_cnt), exp_cnt(1));
        step();

        // Decode disabled.
        in_valid = 1'b1; id_in = 7'h07; en_in = 1'b0;
        step();
        in_valid = 1'b0; en_in = 1'b1;
        chk("dis_valid", 128'(out_valid), 128'd1);
        chk("dis_one_hot", 128'(one_hot_out), 128'd0);
        chk("dis_range_err", 128'(range_err), 128'd0);
        step();

        // Backpressure with ids 3, 4, 5.
        out_ready = 1'b0; in_valid = 1'b1; id_in = 7'd3;
        step();
        chk("bp_ready_1", 128'(in_ready), 128'd1);
        id_in = 7'd4;
        step();
        chk("bp_ready_full", 128'(in_ready), 128'd0);
        chk("bp_head_3", 128'(one_hot_out), bit_of(3));
        id_in = 7'd5;
        step();
        chk("bp_hold_ready", 128'(in_ready), 128'd0);
        chk("bp_hold_head", 128'(one_hot_out), bit_of(3));
        out_ready = 1'b1;
        step();
        chk("bp_head_4", 128'(one_hot_out), bit_of(4));
        chk("bp_ready_again", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        chk("bp_head_5", 128'(one_hot_out), bit_of(5));
        chk("bp_valid_5", 128'(out_valid), 128'd1);
        step();
        chk("bp_drained", 128'(out_valid), 128'd0);

        // Full throughput with ids 0 to 99.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            id_in = 7'(i);
            step();
            chk("tp_valid", 128'(out_valid), 128'd1);
            chk("tp_one_hot", 128'(one_hot_out), bit_of(i));
            chk("tp_ready", 128'(in_ready), 128'd1);
        end
        in_valid = 1'b0;
        step();
        chk("tp_drained", 128'(out_valid), 128'd0);

        // Reset mid-operation with the FIFO full.
        out_ready = 1'b0; in_valid = 1'b1; id_in = 7'd10;
        step();
        id_in = 7'h70;
        step();
        chk("mr_full", 128'(in_ready), 128'd0);
        rst = 1'b1; id_in = 7'd20;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("mr_out_valid", 128'(out_valid), 128'd0);
        chk("mr_in_ready", 128'(in_ready), 128'd1);
        chk("mr_err_cnt", 128'(err_cnt), 128'd0);
        chk("mr_one_hot", 128'(one_hot_out), 128'd0);
        step();
        chk("mr_stays_empty", 128'(out_valid), 128'd0);

        // Saturation over 300 out-of-range beats.
        in_valid = 1'b1; id_in = 7'd127; en_in = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 200 || k == 255 || k == 300) begin
                chk("sat_err_cnt", 128'(err_cnt), exp_cnt(k));
            end
        end
        in_valid = 1'b0;
        step();
        step();
        chk("sat_hold", 128'(err_cnt), exp_cnt(300));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
